// File: rtl/flags_shadow_stack.sv
// Processor flag register with a LIFO shadow stack that saves and restores flags
// across nested interrupts. Overflow and underflow raise a sticky error flag.
module flags_shadow_stack #(
   parameter int NFLAGS = 2,
   parameter int DEPTH  = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [NFLAGS-1:0] FLG_SET,
   input  logic [NFLAGS-1:0] FLG_CLR,
   input  logic [NFLAGS-1:0] FLG_LD,
   input  logic [NFLAGS-1:0] FLG_IN,
   input  logic              FLG_PUSH,
   input  logic              FLG_POP,
   input  logic              ERR_CLR,
   output logic [NFLAGS-1:0] FLG_OUT,
   output logic [CW-1:0]     SHAD_CNT,
   output logic              SHAD_FULL,
   output logic              SHAD_EMPTY,
   output logic              SHAD_ERR
);

   logic [NFLAGS-1:0] stack [DEPTH];
   logic [NFLAGS-1:0] upd_flags;
   logic [NFLAGS-1:0] top_val;
   logic [NFLAGS-1:0] flags_next;
   logic              push_v;
   logic              pop_v;
   logic              swap_v;
   logic              ovf;
   logic              unf;

   assign SHAD_FULL  = (SHAD_CNT == CW'(DEPTH));
   assign SHAD_EMPTY = (SHAD_CNT == '0);

   assign push_v = FLG_PUSH & ~FLG_POP & ~SHAD_FULL;
   assign pop_v  = FLG_POP & ~FLG_PUSH & ~SHAD_EMPTY;
   assign swap_v = FLG_PUSH & FLG_POP & ~SHAD_EMPTY;
   assign ovf    = FLG_PUSH & ~FLG_POP & SHAD_FULL;
   assign unf    = FLG_POP & SHAD_EMPTY;

   // Priority per bit: clear over set over load, otherwise hold.
   always_comb begin
      upd_flags = FLG_OUT;
      for (int unsigned i = 0; i < NFLAGS; i++) begin
         if (FLG_CLR[i])
            upd_flags[i] = 1'b0;
         else if (FLG_SET[i])
            upd_flags[i] = 1'b1;
         else if (FLG_LD[i])
            upd_flags[i] = FLG_IN[i];
      end
   end

   // Top-of-stack select by comparison avoids narrow index arithmetic on SHAD_CNT.
   always_comb begin
      top_val = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (SHAD_CNT == CW'(i + 1))
            top_val = stack[i];
      end
   end

   always_comb begin
      flags_next = upd_flags;
      if (pop_v || swap_v)
         flags_next = top_val;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         FLG_OUT  <= '0;
         SHAD_CNT <= '0;
         SHAD_ERR <= 1'b0;
      end else begin
         FLG_OUT <= flags_next;
         if (push_v)
            SHAD_CNT <= SHAD_CNT + CW'(1);
         else if (pop_v)
            SHAD_CNT <= SHAD_CNT - CW'(1);
         if (ovf || unf)
            SHAD_ERR <= 1'b1;
         else if (ERR_CLR)
            SHAD_ERR <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if ((push_v && SHAD_CNT == CW'(i)) || (swap_v && SHAD_CNT == CW'(i + 1)))
            stack[i] <= FLG_OUT;
      end
   end

endmodule

// File: tb/tb_flags_shadow_stack.sv
// Directed bench for flags_shadow_stack (NFLAGS=2, DEPTH=4) with hand-computed expectations.
module tb_flags_shadow_stack;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [1:0] FLG_SET, FLG_CLR, FLG_LD, FLG_IN;
   logic       FLG_PUSH, FLG_POP, ERR_CLR;
   logic [1:0] FLG_OUT;
   logic [2:0] SHAD_CNT;
   logic       SHAD_FULL, SHAD_EMPTY, SHAD_ERR;

   int checks = 0;
   int errors = 0;

   flags_shadow_stack #(.NFLAGS(2), .DEPTH(4)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .FLG_SET(FLG_SET), .FLG_CLR(FLG_CLR), .FLG_LD(FLG_LD), .FLG_IN(FLG_IN),
      .FLG_PUSH(FLG_PUSH), .FLG_POP(FLG_POP), .ERR_CLR(ERR_CLR),
      .FLG_OUT(FLG_OUT), .SHAD_CNT(SHAD_CNT), .SHAD_FULL(SHAD_FULL),
      .SHAD_EMPTY(SHAD_EMPTY), .SHAD_ERR(SHAD_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic clr_in();
      FLG_SET = '0; FLG_CLR = '0; FLG_LD = '0; FLG_IN = '0;
      FLG_PUSH = 1'b0; FLG_POP = 1'b0; ERR_CLR = 1'b0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      clr_in();
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input logic [1:0] f, input logic [2:0] c,
                         input logic e);
      chk({tag, "_flg"}, 8'(FLG_OUT), 8'(f));
      chk({tag, "_cnt"}, 8'(SHAD_CNT), 8'(c));
      chk({tag, "_err"}, 8'(SHAD_ERR), 8'(e));
   endtask

   task automatic load(input logic [1:0] v);
      FLG_LD = 2'b11; FLG_IN = v;
   endtask

   initial begin
      RST_N = 1'b0;
      clr_in();
      #1;
      chk_st("reset", 2'b00, 3'd0, 1'b0);
      chk("reset_empty", 8'(SHAD_EMPTY), 8'd1);
      chk("reset_full", 8'(SHAD_FULL), 8'd0);
      @(posedge CLK); @(posedge CLK); #1;
      RST_N = 1'b1;

      // Priority
      load(2'b11); tick();
      chk("ld11", 8'(FLG_OUT), 8'b11);
      FLG_CLR = 2'b01; FLG_SET = 2'b01; tick();
      chk("clr_wins", 8'(FLG_OUT), 8'b10);

      // Push with clear, pop overrides set
      FLG_SET = 2'b11; tick();
      FLG_PUSH = 1'b1; FLG_CLR = 2'b11; tick();
      chk_st("push_clr", 2'b00, 3'd1, 1'b0);
      FLG_POP = 1'b1; FLG_SET = 2'b11; tick();
      chk_st("pop_set", 2'b11, 3'd0, 1'b0);

      // Nested
      load(2'b01); tick();
      FLG_PUSH = 1'b1; tick();
      load(2'b10); tick();
      FLG_PUSH = 1'b1; tick();
      chk("nest_cnt2", 8'(SHAD_CNT), 8'd2);
      load(2'b00); tick();
      FLG_POP = 1'b1; tick();
      chk_st("nest_pop1", 2'b10, 3'd1, 1'b0);
      FLG_POP = 1'b1; tick();
      chk_st("nest_pop2", 2'b01, 3'd0, 1'b0);
      chk("nest_empty", 8'(SHAD_EMPTY), 8'd1);

      // Fill and overflow; FLG_OUT=01 here
      FLG_PUSH = 1'b1; load(2'b10); tick();
      FLG_PUSH = 1'b1; load(2'b11); tick();
      FLG_PUSH = 1'b1; load(2'b00); tick();
      FLG_PUSH = 1'b1; load(2'b01); tick();
      chk_st("fill4", 2'b01, 3'd4, 1'b0);
      chk("fill4_full", 8'(SHAD_FULL), 8'd1);
      FLG_PUSH = 1'b1; load(2'b10); tick();
      chk_st("ovf", 2'b10, 3'd4, 1'b1);
      FLG_POP = 1'b1; tick();
      chk_st("lifo1", 2'b00, 3'd3, 1'b1);
      FLG_POP = 1'b1; tick();
      chk("lifo2", 8'(FLG_OUT), 8'b11);
      FLG_POP = 1'b1; tick();
      chk("lifo3", 8'(FLG_OUT), 8'b10);
      FLG_POP = 1'b1; tick();
      chk_st("lifo4", 2'b01, 3'd0, 1'b1);
      ERR_CLR = 1'b1; tick();
      chk("errclr", 8'(SHAD_ERR), 8'd0);

      // Underflow, and error coincident with ERR_CLR
      FLG_POP = 1'b1; load(2'b01); tick();
      chk_st("unf", 2'b01, 3'd0, 1'b1);
      ERR_CLR = 1'b1; tick();
      chk("errclr2", 8'(SHAD_ERR), 8'd0);
      FLG_POP = 1'b1; ERR_CLR = 1'b1; tick();
      chk("err_wins", 8'(SHAD_ERR), 8'd1);
      ERR_CLR = 1'b1; tick();

      // Swap: top=10, FLG_OUT=01
      load(2'b10); tick();
      FLG_PUSH = 1'b1; load(2'b01); tick();
      chk_st("pre_swap", 2'b01, 3'd1, 1'b0);
      FLG_PUSH = 1'b1; FLG_POP = 1'b1; FLG_SET = 2'b11; tick();
      chk_st("swap", 2'b10, 3'd1, 1'b0);
      FLG_POP = 1'b1; tick();
      chk_st("swap_top", 2'b01, 3'd0, 1'b0);

      // Push+pop on empty is underflow, flag updates still apply
      FLG_PUSH = 1'b1; FLG_POP = 1'b1; load(2'b11); tick();
      chk_st("pp_empty", 2'b11, 3'd0, 1'b1);
      ERR_CLR = 1'b1; tick();

      // Async reset mid-operation
      FLG_PUSH = 1'b1; tick();
      FLG_PUSH = 1'b1; tick();
      FLG_PUSH = 1'b1; FLG_SET = 2'b11; tick();
      chk_st("pre_rst", 2'b11, 3'd3, 1'b0);
      #2 RST_N = 1'b0;
      #1;
      chk_st("async_rst", 2'b00, 3'd0, 1'b0);
      chk("async_rst_empty", 8'(SHAD_EMPTY), 8'd1);
      #2 RST_N = 1'b1;
      FLG_POP = 1'b1; tick();
      chk_st("post_rst_pop", 2'b00, 3'd0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
